// File: rtl/boot_pkg.sv
// Shared constants for the instruction-cache boot loader.
package boot_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

  // Loader states, kept as fixed encodings for compatibility with older tooling.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_HDR   = 3'd1;
  localparam state_t S_DATA  = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_CSUM  = 3'd4;
  localparam state_t S_DONE  = 3'd5;
  localparam state_t S_ERR   = 3'd6;

  // Sticky error codes reported on err.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input, icache boot port and status of the boot loader.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);

  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              boot_up;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_datai;
  logic              boot_web;
  logic              done;
  logic [1:0]        err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, boot_up, boot_addr, boot_datai, boot_web, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, boot_up, boot_addr, boot_datai, boot_web, done, err
  );

endinterface

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler with its own byte counter.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] byte_cnt;

  // full flags the load that completes the current word.
  assign full = load && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  // Place each loaded byte at byte_cnt*8, wrapping the counter after the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      word[{byte_cnt, 3'b000} +: 8] <= byte_in;
      byte_cnt <= full ? '0 : byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams a header-counted, checksummed byte image into the icache boot port.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic          clk,
  input logic          rst_n,
  boot_loader_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic [7:0]        word_idx;
  logic [7:0]        last_idx;
  logic [7:0]        csum;
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_q;
  logic [WORD_W-1:0] word;
  logic              done_q;
  logic [1:0]        err_q;
  logic              rx_state;
  logic              accept;
  logic              start_ok;
  logic              data_load;
  logic              word_full;
  logic              timed_out;

  assign rx_state  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign accept    = rx_state && bus.in_valid;
  assign start_ok  = bus.start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign data_load = accept && (state == S_DATA);
  // An accepted byte always beats an expiring timer.
  assign timed_out = rx_state && !accept && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign wr_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);

  boot_word_asm u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_ok),
    .load    (data_load),
    .byte_in (bus.in_data),
    .word    (word),
    .full    (word_full)
  );

  // The write port is live only in WRITE; otherwise it shows the last written word.
  assign bus.in_ready   = rx_state;
  assign bus.boot_up    = (state != S_IDLE) && (state != S_DONE);
  assign bus.boot_web   = (state != S_WRITE);
  assign bus.boot_addr  = (state == S_WRITE) ? wr_addr : addr_q;
  assign bus.boot_datai = (state == S_WRITE) ? DATA_W'(word) : data_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // Load sequencing: header, data words with one write cycle each, checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      word_idx <= '0;
      last_idx <= '0;
      csum     <= '0;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_ok) begin
            state    <= S_HDR;
            word_idx <= '0;
            csum     <= '0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
          end
        end
        S_HDR: begin
          if (accept) begin
            // A header of 0 wraps to last_idx 255, i.e. 256 words.
            last_idx <= bus.in_data - 8'd1;
            csum     <= bus.in_data;
            state    <= S_DATA;
          end else if (timed_out) begin
            state <= S_ERR;
            err_q <= ERR_TMO;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ bus.in_data;
            if (word_full) state <= S_WRITE;
          end else if (timed_out) begin
            state <= S_ERR;
            err_q <= ERR_TMO;
          end
        end
        S_WRITE: begin
          if (word_idx == last_idx) begin
            state <= S_CSUM;
          end else begin
            word_idx <= word_idx + 8'd1;
            state    <= S_DATA;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (bus.in_data == csum) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_ERR;
              err_q <= ERR_CSUM;
            end
          end else if (timed_out) begin
            state <= S_ERR;
            err_q <= ERR_TMO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Idle timer: runs while waiting for a byte, frozen in WRITE, cleared on any accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (start_ok || accept || timed_out) begin
      timer <= '0;
    end else if (rx_state) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Capture the written address/data so the port holds them after WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (state == S_WRITE) begin
      addr_q <= wr_addr;
      data_q <= DATA_W'(word);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: two instances (base 00 and FE) share one stimulus stream.
`timescale 1ns/1ps
module tb_boot_loader;
  import boot_pkg::*;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;

  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(8), .DATA_W(32)) bl ();
  boot_loader_if #(.ADDR_W(8), .DATA_W(32)) bh ();

  assign bl.start = start;  assign bl.in_valid = in_valid;  assign bl.in_data = in_data;
  assign bh.start = start;  assign bh.in_valid = in_valid;  assign bh.in_data = in_data;

  boot_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0), .TIMEOUT_CYC(16)) dut_lo (
    .clk(clk), .rst_n(rst_n), .bus(bl));
  boot_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(254), .TIMEOUT_CYC(16)) dut_hi (
    .clk(clk), .rst_n(rst_n), .bus(bh));

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        vld;
    int unsigned cyc;
  } wr_t;

  wr_t         wq_lo[$];
  wr_t         wq_hi[$];
  wr_t         elo, ehi;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] words [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe seen on each instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bl.boot_web === 1'b0) begin
      elo.addr = bl.boot_addr; elo.data = bl.boot_datai; elo.rdy = bl.in_ready;
      elo.vld = in_valid; elo.cyc = cyc;
      wq_lo.push_back(elo);
    end
    if (rst_n === 1'b1 && bh.boot_web === 1'b0) begin
      ehi.addr = bh.boot_addr; ehi.data = bh.boot_datai; ehi.rdy = bh.in_ready;
      ehi.vld = in_valid; ehi.cyc = cyc;
      wq_hi.push_back(ehi);
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (bl.in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bl.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte: byte %02h never accepted, in_ready=%b required 1", b, bl.in_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_stream(input int unsigned n, input logic [7:0] csum_b);
    logic [31:0] w;
    logic [7:0]  hdr;
    hdr = n[7:0];
    send_byte(hdr);
    for (int unsigned i = 0; i < n; i++) begin
      w = words[i];
      for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    send_byte(csum_b);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bl.boot_up !== 1'b0) begin n_fail++; $display("FAIL reset_boot_up: got %b want 0", bl.boot_up); end
    n_checks++; if (bl.boot_web !== 1'b1) begin n_fail++; $display("FAIL reset_boot_web: got %b want 1", bl.boot_web); end
    n_checks++; if (bl.boot_addr !== 8'h00) begin n_fail++; $display("FAIL reset_boot_addr: got %02h want 00", bl.boot_addr); end
    n_checks++; if (bl.boot_datai !== 32'h0) begin n_fail++; $display("FAIL reset_boot_datai: got %08h want 0", bl.boot_datai); end
    n_checks++; if (bl.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bl.in_ready); end
    n_checks++; if (bl.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bl.done); end
    n_checks++; if (bl.err !== ERR_NONE) begin n_fail++; $display("FAIL reset_err: got %b want 00", bl.err); end
    n_checks++; if (bh.boot_addr !== 8'h00) begin n_fail++; $display("FAIL reset_hi_addr: got %02h want 00", bh.boot_addr); end
    rst_n = 1'b1;
    // A valid byte while idle must not be taken.
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) @(negedge clk);
    n_checks++; if (bl.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", bl.in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_load_n2();
    wq_lo.delete(); wq_hi.delete();
    words[0] = 32'h44332211; words[1] = 32'hDDCCBBAA;
    pulse_start();
    n_checks++; if (bl.boot_up !== 1'b1) begin n_fail++; $display("FAIL n2_boot_up_hdr: got %b want 1", bl.boot_up); end
    run_stream(2, 8'h46);
    n_checks++; if (wq_lo.size() != 2) begin n_fail++; $display("FAIL n2_strobes: got %0d want 2", wq_lo.size()); end
    if (wq_lo.size() == 2) begin
      n_checks++; if (wq_lo[0].addr !== 8'h00 || wq_lo[0].data !== 32'h44332211) begin n_fail++;
        $display("FAIL n2_word0: got %02h/%08h want 00/44332211", wq_lo[0].addr, wq_lo[0].data); end
      n_checks++; if (wq_lo[1].addr !== 8'h01 || wq_lo[1].data !== 32'hDDCCBBAA) begin n_fail++;
        $display("FAIL n2_word1: got %02h/%08h want 01/DDCCBBAA", wq_lo[1].addr, wq_lo[1].data); end
    end
    if (wq_hi.size() == 2) begin
      n_checks++; if (wq_hi[0].addr !== 8'hFE || wq_hi[1].addr !== 8'hFF) begin n_fail++;
        $display("FAIL n2_hi_addr: got %02h,%02h want FE,FF", wq_hi[0].addr, wq_hi[1].addr); end
    end
    n_checks++; if (bl.done !== 1'b1) begin n_fail++; $display("FAIL n2_done: got %b want 1", bl.done); end
    n_checks++; if (bl.boot_up !== 1'b0) begin n_fail++; $display("FAIL n2_boot_up: got %b want 0", bl.boot_up); end
    n_checks++; if (bl.err !== ERR_NONE) begin n_fail++; $display("FAIL n2_err: got %b want 00", bl.err); end
    n_checks++; if (bl.boot_addr !== 8'h01 || bl.boot_datai !== 32'hDDCCBBAA) begin n_fail++;
      $display("FAIL n2_hold: got %02h/%08h want 01/DDCCBBAA", bl.boot_addr, bl.boot_datai); end
  endtask

  task automatic test_bad_csum();
    wq_lo.delete(); wq_hi.delete();
    words[0] = 32'h44332211; words[1] = 32'hDDCCBBAA;
    pulse_start();
    run_stream(2, 8'h47);
    n_checks++; if (wq_lo.size() != 2) begin n_fail++; $display("FAIL bad_strobes: got %0d want 2", wq_lo.size()); end
    n_checks++; if (bl.err !== ERR_CSUM) begin n_fail++; $display("FAIL bad_err: got %b want 01", bl.err); end
    n_checks++; if (bl.done !== 1'b0) begin n_fail++; $display("FAIL bad_done: got %b want 0", bl.done); end
    n_checks++; if (bl.boot_up !== 1'b1) begin n_fail++; $display("FAIL bad_boot_up: got %b want 1", bl.boot_up); end
    n_checks++; if (bl.in_ready !== 1'b0) begin n_fail++; $display("FAIL bad_in_ready: got %b want 0", bl.in_ready); end
  endtask

  task automatic test_timeout();
    wq_lo.delete(); wq_hi.delete();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++; if (bl.err !== ERR_NONE || bl.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL tmo_early: got err=%b in_ready=%b want 00/1 after 15 idle cycles", bl.err, bl.in_ready); end
    @(negedge clk);
    n_checks++; if (bl.err !== ERR_TMO) begin n_fail++; $display("FAIL tmo_err: got %b want 10", bl.err); end
    n_checks++; if (bl.boot_up !== 1'b1) begin n_fail++; $display("FAIL tmo_boot_up: got %b want 1", bl.boot_up); end
    n_checks++; if (bl.in_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_in_ready: got %b want 0", bl.in_ready); end
    n_checks++; if (wq_lo.size() != 0) begin n_fail++; $display("FAIL tmo_strobes: got %0d want 0", wq_lo.size()); end
  endtask

  task automatic test_wrap_n0();
    logic [7:0] ib;
    logic [7:0] cs;
    wq_lo.delete(); wq_hi.delete();
    cs = 8'h00;
    for (int unsigned i = 0; i < 256; i++) begin
      ib = i[7:0];
      words[i] = {ib, ib ^ 8'h5A, ~ib, ib + 8'd3};
      cs = cs ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    end
    pulse_start();
    run_stream(256, cs);
    n_checks++; if (wq_hi.size() != 256) begin n_fail++; $display("FAIL wrap_strobes: got %0d want 256", wq_hi.size()); end
    for (int unsigned i = 0; i < wq_hi.size() && i < 256; i++) begin
      ib = 8'hFE + i[7:0];
      n_checks++; if (wq_hi[i].addr !== ib || wq_hi[i].data !== words[i]) begin n_fail++;
        $display("FAIL wrap_word%0d: got %02h/%08h want %02h/%08h", i, wq_hi[i].addr, wq_hi[i].data, ib, words[i]); end
    end
    n_checks++; if (wq_lo.size() != 256 || wq_lo[255].addr !== 8'hFF) begin n_fail++;
      $display("FAIL wrap_lo_last: got %0d strobes, want 256 ending at FF", wq_lo.size()); end
    n_checks++; if (bh.done !== 1'b1 || bh.err !== ERR_NONE) begin n_fail++;
      $display("FAIL wrap_done: got done=%b err=%b want 1/00", bh.done, bh.err); end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w;
    wq_lo.delete(); wq_hi.delete();
    pulse_start();
    send_byte(8'h08);
    for (int unsigned i = 0; i < 5; i++) begin
      w = words[i];
      for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    w = words[5];
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    n_checks++; if (bl.boot_addr !== 8'h04 || bl.boot_datai !== words[4]) begin n_fail++;
      $display("FAIL mid_hold: got %02h/%08h want 04/%08h", bl.boot_addr, bl.boot_datai, words[4]); end
    in_valid = 1'b1; in_data = w[23:16];
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bl.boot_up !== 1'b0) begin n_fail++; $display("FAIL mid_boot_up: got %b want 0", bl.boot_up); end
    n_checks++; if (bl.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", bl.in_ready); end
    n_checks++; if (bl.boot_web !== 1'b1) begin n_fail++; $display("FAIL mid_boot_web: got %b want 1", bl.boot_web); end
    n_checks++; if (bl.boot_addr !== 8'h00) begin n_fail++; $display("FAIL mid_boot_addr: got %02h want 00", bl.boot_addr); end
    n_checks++; if (bl.boot_datai !== 32'h0) begin n_fail++; $display("FAIL mid_boot_datai: got %08h want 0", bl.boot_datai); end
    n_checks++; if (bl.done !== 1'b0 || bl.err !== ERR_NONE) begin n_fail++;
      $display("FAIL mid_status: got done=%b err=%b want 0/00", bl.done, bl.err); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    wq_lo.delete(); wq_hi.delete();
    words[0] = 32'h44332211; words[1] = 32'hDDCCBBAA;
    pulse_start();
    run_stream(2, 8'h46);
    n_checks++; if (wq_lo.size() != 2 || wq_lo[0].addr !== 8'h00 || wq_lo[0].data !== 32'h44332211) begin n_fail++;
      $display("FAIL mid_restart: got %0d strobes, want 2 starting at 00/44332211", wq_lo.size()); end
    n_checks++; if (bl.done !== 1'b1) begin n_fail++; $display("FAIL mid_restart_done: got %b want 1", bl.done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    wq_lo.delete(); wq_hi.delete();
    words[0] = 32'h03020100; words[1] = 32'h07060504; words[2] = 32'h0B0A0908;
    pulse_start();
    send_byte(8'h03);
    for (int unsigned i = 0; i < 3; i++) begin
      w = words[i];
      for (int unsigned k = 0; k < 4; k++) begin
        if (i == 1 && k == 2) start = 1'b1;
        send_byte(w[8*k +: 8]);
        start = 1'b0;
      end
    end
    // XOR of header 03 and bytes 00..0B is 03.
    send_byte(8'h03);
    in_valid = 1'b0;
    n_checks++; if (wq_lo.size() != 3) begin n_fail++; $display("FAIL b2b_strobes: got %0d want 3", wq_lo.size()); end
    for (int unsigned i = 0; i < wq_lo.size() && i < 3; i++) begin
      n_checks++; if (wq_lo[i].addr !== i[7:0] || wq_lo[i].data !== words[i]) begin n_fail++;
        $display("FAIL b2b_word%0d: got %02h/%08h want %02h/%08h", i, wq_lo[i].addr, wq_lo[i].data, i[7:0], words[i]); end
      n_checks++; if (wq_lo[i].rdy !== 1'b0 || wq_lo[i].vld !== 1'b1) begin n_fail++;
        $display("FAIL b2b_write_ready%0d: got ready=%b valid=%b want 0/1", i, wq_lo[i].rdy, wq_lo[i].vld); end
      if (i > 0) begin
        n_checks++; if (wq_lo[i].cyc - wq_lo[i-1].cyc != 5) begin n_fail++;
          $display("FAIL b2b_gap%0d: got %0d cycles want 5", i, wq_lo[i].cyc - wq_lo[i-1].cyc); end
      end
    end
    n_checks++; if (bl.done !== 1'b1 || bl.err !== ERR_NONE) begin n_fail++;
      $display("FAIL b2b_done: got done=%b err=%b want 1/00", bl.done, bl.err); end
  endtask

  initial begin
    test_reset();
    test_load_n2();
    test_bad_csum();
    test_timeout();
    test_wrap_n0();
    test_reset_midload();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 1000000", $time);
    $fatal(1);
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream feeder for the pipeline top's instruction-cache boot port (boot_up / boot_addr / boot_datai / boot_web).
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into icache on consecutive addresses, then verifies an XOR checksum.
- Releases boot_up on success, which lets PC_run start the core. On failure, holds the core in boot.

Parameters:
- ADDR_W, 8, icache word-address width; equals boot_addr width.
- DATA_W, 32, instruction word width; 4 bytes.
- BASE_ADDR, 0, first icache address written.
- TIMEOUT_CYC, 1024, maximum idle cycles between accepted bytes while loading.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; ignored unless in IDLE, DONE or ERR.
- in_valid  in  1  byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  byte accepted when in_valid & in_ready at rising edge.
- boot_up  out  1  high while loading or in error; holds the core in boot.
- boot_addr  out  ADDR_W  icache write address.
- boot_datai  out  DATA_W  icache write data.
- boot_web  out  1  icache write strobe, active low, one cycle per word.
- done  out  1  sticky load-success flag.
- err  out  2  sticky error code: 00 none, 01 checksum, 10 timeout.

Behaviour:
- Reset (async, rst_n=0), applied at any time including mid-load:
  - state IDLE.
  - boot_up=0, boot_web=1, boot_addr=0, boot_datai=0, in_ready=0, done=0, err=00.
  - All counters and the checksum register cleared.
- States: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Go to HDR; boot_up=1 from the next cycle.
  - Clear done, err, the checksum register, word_idx, byte_cnt and the timer.
- HDR:
  - in_ready=1. The accepted byte is N, the word count; N=0 means 256 words.
  - The checksum register starts as N.
  - Go to DATA.
- DATA:
  - in_ready=1. Each accepted byte goes into the word at byte_cnt*8, LSB first. The byte is XORed into the checksum and byte_cnt increments.
  - The 4th byte moves to WRITE on the next cycle; byte_cnt returns to 0.
- WRITE (exactly one cycle):
  - in_ready=0, boot_web=0.
  - boot_addr = (BASE_ADDR + word_idx) mod 2^ADDR_W, i.e. wraps.
  - boot_datai = assembled word.
  - If word_idx == N-1, go to CSUM, else increment word_idx and go to DATA.
- boot_addr and boot_datai hold their last value outside WRITE; boot_web=1 outside WRITE.
- CSUM:
  - in_ready=1. Compare the accepted byte with the checksum register.
  - Equal: go to DONE; done=1; boot_up=0 on the next cycle.
  - Not equal: go to ERR; err=01; boot_up stays 1.
- Timer:
  - Counts cycles in HDR/DATA/CSUM and clears on each accepted byte. It is not counted in WRITE.
  - Reaching TIMEOUT_CYC goes to ERR with err=10.
  - If the timer expires in the same cycle a byte is accepted, the byte wins and the timer clears.
- in_ready=0 in IDLE, WRITE, DONE and ERR; bytes presented there are not consumed.
- start while in HDR/DATA/WRITE/CSUM is ignored.
- Throughput: 5 cycles per word minimum (4 byte cycles + 1 WRITE).

Decomposition:
- Package boot_pkg holds:
  - the state enum;
  - the err code constants ERR_NONE, ERR_CSUM, ERR_TMO;
  - BYTES_PER_WORD = DATA_W/8.
- One sub-module, boot_word_asm, holds the byte shift/assembly register and byte_cnt.
  - Inputs: load strobe and byte.
  - Outputs: word and full flag.
  - It is cleared by the parent's start or reset.

Test Plan:
- Load N=2:
  - Stream 02, 11 22 33 44, AA BB CC DD, checksum 02^11^22^33^44^AA^BB^CC^DD.
  - Required: boot_web low for exactly 2 cycles with addr 00/data 44332211, then addr 01/data DDCCBBAA.
  - Then done=1, boot_up falls, err=00.
- Bad checksum:
  - Same stream with the checksum XOR 01.
  - Required: both words written, err=01, done=0, boot_up stays 1, in_ready=0.
- Timeout:
  - TIMEOUT_CYC=16, N=1, in_valid dropped after 2 data bytes.
  - Required: err=10 exactly 16 idle cycles after the last accepted byte; no boot_web pulse.
- Wrap/N=0:
  - BASE_ADDR=FE, header 00, 256 words with pattern data, correct checksum.
  - Required: addresses FE, FF, 00 … FD, 256 strobes, done=1.
- Reset mid-load:
  - Assert rst_n=0 during DATA byte 3 of word 5.
  - Required: all outputs at reset values immediately (async); a new start restarts from word 0 at BASE_ADDR.
- Backpressure/start-ignore:
  - Keep in_valid=1 during WRITE and pulse start in DATA.
  - Required: no byte consumed in WRITE; the load is unaffected; the byte order is preserved.
